// File: rtl/fifo_stream_unpacker.sv
// fifo_stream_unpacker
// Read-side stage behind the synchronous FIFO. It pulls DATA_WIDTH-bit words
// and serialises each one into RATIO = DATA_WIDTH/OUT_WIDTH beats on a
// valid/ready stream. A one-word prefetch slot hides the FIFO's read latency
// and its stale empty flag, so beats stream without bubbles.
module fifo_stream_unpacker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [OUT_WIDTH-1:0]  m_data_o,
  output logic                  m_last_o
);

  localparam int unsigned RATIO    = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W    = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  // Reject word/beat geometries that cannot be serialised evenly.
  if (((DATA_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_param_check
    $error("fifo_stream_unpacker: DATA_WIDTH must be a multiple of OUT_WIDTH with a ratio of at least 2");
  end

  // Shift register holding the word being serialised, plus the prefetch slot.
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  sh_valid_q, sh_valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pf_q, pf_d;
  logic                  pf_valid_q, pf_valid_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  last_q, last_d;

  logic accept;
  logic at_last;
  logic last_acc;
  logic pf_to_sh;
  logic cap_to_sh;
  logic cap_to_pf;

  // Issue a read only when the returning word is guaranteed a home and the
  // empty flag is not stale: never in the cycle right after another read.
  assign fifo_rd_en_o = !reset && !fifo_empty_i && !rd_pend_q && !pf_valid_q;

  assign m_valid_o = sh_valid_q;
  assign m_data_o  = LSB_FIRST ? sh_q[OUT_WIDTH-1:0] : sh_q[DATA_WIDTH-1 -: OUT_WIDTH];
  assign m_last_o  = last_q;

  assign accept   = sh_valid_q && m_ready_i;
  assign at_last  = (cnt_q == CNT_LAST);
  assign last_acc = accept && at_last;

  // The word returning from the FIFO goes straight to the shift register when
  // that slot frees up this cycle and nothing older is waiting in prefetch.
  assign pf_to_sh  = last_acc && pf_valid_q;
  assign cap_to_sh = rd_pend_q && (!sh_valid_q || (last_acc && !pf_valid_q));
  assign cap_to_pf = rd_pend_q && !cap_to_sh;

  // Next-state: shift on mid-word accepts, refill on the last beat, capture reads.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned;
    // otherwise synthesis infers a latch to hold the old value.
    sh_d       = sh_q;
    sh_valid_d = sh_valid_q;
    cnt_d      = cnt_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    rd_pend_d  = fifo_rd_en_o;

    if (accept && !at_last) begin
      sh_d  = LSB_FIRST ? (sh_q >> OUT_WIDTH) : (sh_q << OUT_WIDTH);
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (last_acc) begin
      cnt_d      = '0;
      sh_d       = '0;
      sh_valid_d = 1'b0;
    end

    if (pf_to_sh) begin
      sh_d       = pf_q;
      sh_valid_d = 1'b1;
      pf_d       = '0;
      pf_valid_d = 1'b0;
    end

    if (cap_to_sh) begin
      sh_d       = fifo_rd_data_i;
      sh_valid_d = 1'b1;
      cnt_d      = '0;
    end

    // Ordered after the prefetch pop so a simultaneous move and capture
    // leaves the newer word in the prefetch slot.
    if (cap_to_pf) begin
      pf_d       = fifo_rd_data_i;
      pf_valid_d = 1'b1;
    end

    last_d = sh_valid_d && (cnt_d == CNT_LAST);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (reset) begin
      sh_q       <= '0;
      sh_valid_q <= 1'b0;
      cnt_q      <= '0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      sh_valid_q <= sh_valid_d;
      cnt_q      <= cnt_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      rd_pend_q  <= rd_pend_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_unpacker.sv
// Testbench for fifo_stream_unpacker: a behavioural FIFO (registered, one-cycle
// lagging empty flag, one-cycle read latency) feeds the DUT; a scoreboard built
// from the words pushed into that FIFO predicts every output beat.
module tb_fifo_stream_unpacker;

  localparam int DW    = 32;
  localparam int OW    = 8;
  localparam int RATIO = DW / OW;
  localparam bit LSB   = 1'b1;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty_i = 1'b1;
  logic [DW-1:0] fifo_rd_data_i = '0;
  logic          fifo_rd_en_o;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [OW-1:0] m_data_o;
  logic          m_last_o;

  fifo_stream_unpacker #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .LSB_FIRST (LSB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_rd_en_o  (fifo_rd_en_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_data_o      (m_data_o),
    .m_last_o      (m_last_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  beat_t         exp_q[$];

  int checks = 0;
  int errors = 0;
  int beats_acc = 0;
  int rd_count = 0;

  logic          s_rd = 1'b0, s_valid = 1'b0, s_last = 1'b0, s_empty = 1'b1;
  logic          s_rd_prev = 1'b0;
  logic [OW-1:0] s_data = '0;
  logic          hold_pending = 1'b0, h_last = 1'b0;
  logic [OW-1:0] h_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat k of word w, straight from the ordering rule.
  function automatic logic [OW-1:0] beat_of(input logic [DW-1:0] w, input int k);
    if (LSB) return OW'(w >> (k * OW));
    else     return OW'(w >> (DW - (k + 1) * OW));
  endfunction

  task automatic push_word(input logic [DW-1:0] w);
    beat_t b;
    fifo_q.push_back(w);
    for (int k = 0; k < RATIO; k++) begin
      b.data = beat_of(w, k);
      b.last = (k == RATIO - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock: sample and check this cycle's outputs, then let the FIFO model
  // react to the read request seen at the edge.
  task automatic cycle();
    beat_t b;
    logic  was_empty;
    #1;
    s_rd    = fifo_rd_en_o;
    s_valid = m_valid_o;
    s_data  = m_data_o;
    s_last  = m_last_o;
    s_empty = fifo_empty_i;
    if (hold_pending) begin
      check("hold_valid", s_valid, 1'b1);
      check("hold_data", s_data, h_data);
      check("hold_last", s_last, h_last);
    end
    check("rd_back_to_back", s_rd & s_rd_prev, 1'b0);
    check("rd_while_empty", s_rd & s_empty, 1'b0);
    if (s_rd) rd_count++;
    if (s_valid && m_ready_i) begin
      check("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        check("beat_data", s_data, b.data);
        check("beat_last", s_last, b.last);
      end
      beats_acc++;
    end
    hold_pending = s_valid && !m_ready_i;
    h_data       = s_data;
    h_last       = s_last;
    s_rd_prev    = s_rd;
    @(posedge clk);
    #1;
    was_empty = (fifo_q.size() == 0);
    if (s_rd && fifo_q.size() != 0) fifo_rd_data_i = fifo_q.pop_front();
    fifo_empty_i = was_empty;
  endtask

  // Asynchronous reset of DUT and FIFO model together.
  task automatic do_reset(input int hold_cycles);
    reset = 1'b1;
    #1;
    check("rst_rd_en", fifo_rd_en_o, 1'b0);
    check("rst_valid", m_valid_o, 1'b0);
    check("rst_data", m_data_o, '0);
    check("rst_last", m_last_o, 1'b0);
    fifo_q.delete();
    exp_q.delete();
    fifo_empty_i = 1'b1;
    hold_pending = 1'b0;
    s_rd_prev    = 1'b0;
    for (int i = 0; i < hold_cycles; i++) cycle();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    m_ready_i = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check(tag, exp_q.size(), 0);
    for (int i = 0; i < 4; i++) cycle();
    check("drain_idle", s_valid, 1'b0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle();
      found = s_valid;
    end
    check(tag, found, 1'b1);
  endtask

  initial begin
    logic [OW-1:0] exp_b [4];
    logic          found;
    int            rd0, beats0;

    // Reset and idle.
    @(posedge clk);
    #1;
    do_reset(3);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("idle_rd_en", s_rd, 1'b0);
      check("idle_valid", s_valid, 1'b0);
    end

    // Single word, first-beat latency and beat order.
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    m_ready_i = 1'b1;
    push_word(32'hA1B2C3D4);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      found = !s_empty;
    end
    check("single_empty_low", found, 1'b1);
    check("single_rd_in_T", s_rd, 1'b1);
    cycle();
    check("single_valid_T1", s_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("single_valid", s_valid, 1'b1);
      check("single_data", s_data, exp_b[k]);
      check("single_last", s_last, (k == 3));
    end
    cycle();
    check("single_done", s_valid, 1'b0);

    // Back-to-back words: no valid gap across 16 beats.
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    wait_valid("b2b_start", 10);
    for (int i = 0; i < 4 * RATIO - 1; i++) begin
      cycle();
      check("b2b_no_gap", s_valid, 1'b1);
    end
    drain("b2b_drain", 20);

    // Backpressure mid-word: outputs hold, reads stop once prefetch is full.
    for (int i = 0; i < 3; i++) push_word(DW'($urandom));
    wait_valid("bp_start", 10);
    m_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_no_read", s_rd, 1'b0);
    end
    drain("bp_drain", 40);

    // Stale empty: a single stored word yields exactly one read.
    rd0    = rd_count;
    beats0 = beats_acc;
    push_word(DW'($urandom));
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      found = s_rd;
    end
    check("stale_rd_seen", found, 1'b1);
    cycle();
    check("stale_no_second_rd", s_rd, 1'b0);
    drain("stale_drain", 20);
    check("stale_rd_count", rd_count - rd0, 1);
    check("stale_beat_count", beats_acc - beats0, RATIO);

    // Reset after two beats with the next word prefetched.
    beats0 = beats_acc;
    push_word(DW'($urandom));
    push_word(DW'($urandom));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = (beats_acc - beats0 == 2);
    end
    check("rstmid_two_beats", found, 1'b1);
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rstmid_idle", s_valid, 1'b0);
    end
    push_word(32'h0F1E2D3C);
    drain("rstmid_drain", 20);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) push_word(DW'($urandom));
      m_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain("rand_drain", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
